servo_pwm_decoder: RTL and testbench

//  Receive end of the servo PWM link. Samples a servo control pulse train and measures each

---
 rtl/servo_pkg.sv | 37 +++
 rtl/servo_us_tick.sv | 32 +++
 rtl/servo_pwm_decoder.sv | 222 ++++++++++++++++++++++
 tb/tb_servo_pwm_decoder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared constants and types for the servo PWM link (driver and decoder sides).
package servo_pkg;

    // Direction encoding consumed by the servo driver; 2'b11 is never produced.
    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_CW   = 2'b01;
    localparam logic [1:0] DIR_CCW  = 2'b10;

    // Default timing, shared with pwm_control.
    localparam int unsigned DEF_CLK_DIV    = 100;
    localparam int unsigned DEF_MIN_US     = 500;
    localparam int unsigned DEF_MAX_US     = 2500;
    localparam int unsigned DEF_CENTER_US  = 1500;
    localparam int unsigned DEF_DEADBAND   = 50;
    localparam int unsigned DEF_TIMEOUT_US = 25000;
    localparam int unsigned DEF_FILT_CYC   = 4;

    typedef enum logic [1:0] {
        StSync = 2'd0,
        StIdle = 2'd1,
        StHigh = 2'd2,
        StMeas = 2'd3
    } state_e;

    // Direction for an in-range width; both deadband edges belong to the moving directions.
    function automatic logic [1:0] dir_from_width(input int unsigned w,
                                                  input int unsigned cw_max,
                                                  input int unsigned ccw_min);
        if (w <= cw_max) begin
            return DIR_CW;
        end else if (w >= ccw_min) begin
            return DIR_CCW;
        end
        return DIR_STOP;
    endfunction

endpackage

// File: rtl/servo_us_tick.sv
// Free-running prescaler: one-cycle tick every CLK_DIV clocks, restarts from 0 on reset.
module servo_us_tick #(
    parameter int unsigned CLK_DIV = 100
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             tick_q;

    // Prescaler counter and registered tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (cnt_q == LAST) begin
            cnt_q  <= '0;
            tick_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_q + CNT_W'(1);
            tick_q <= 1'b0;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/servo_pwm_decoder.sv
// Servo PWM receiver: measures each high pulse in us and classifies it as stop/cw/ccw.
// Optional glitch filter on the synchronized line: define SERVO_GLITCH_FILTER_EN.
module servo_pwm_decoder
    import servo_pkg::*;
#(
    parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
    parameter int unsigned WIDTH_W    = 12,
    parameter int unsigned MIN_US     = DEF_MIN_US,
    parameter int unsigned MAX_US     = DEF_MAX_US,
    parameter int unsigned CW_MAX_US  = DEF_CENTER_US - DEF_DEADBAND,
    parameter int unsigned CCW_MIN_US = DEF_CENTER_US + DEF_DEADBAND,
    parameter int unsigned TIMEOUT_US = DEF_TIMEOUT_US,
    parameter int unsigned FILT_CYC   = DEF_FILT_CYC
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pwm_in,
    output logic [1:0]         direction,
    output logic [WIDTH_W-1:0] width_us,
    output logic               valid,
    output logic               range_err,
    output logic               lost
);

`ifdef SERVO_GLITCH_FILTER_EN
    localparam int unsigned FILT_ON = 1;
`else
    localparam int unsigned FILT_ON = 0;
`endif

    localparam logic [WIDTH_W-1:0] MIN_W   = WIDTH_W'(MIN_US);
    localparam logic [WIDTH_W-1:0] MAX_W   = WIDTH_W'(MAX_US);
    localparam logic [WIDTH_W-1:0] SAT_W   = WIDTH_W'(MAX_US + 1);
    localparam int unsigned        TO_W    = $clog2(TIMEOUT_US + 1);
    localparam logic [TO_W-1:0]    TO_MAX  = TO_W'(TIMEOUT_US);
    localparam logic [TO_W-1:0]    TO_LAST = TO_W'(TIMEOUT_US - 1);

    // Line must stay low longer than the whole sync/filter pipeline before leaving SYNC, so a
    // pulse already high at reset release cannot be mistaken for a fresh rising edge.
    localparam int unsigned        SETTLE_CYC  = 4 + FILT_CYC * FILT_ON;
    localparam int unsigned        SET_W       = $clog2(SETTLE_CYC);
    localparam logic [SET_W-1:0]   SETTLE_LAST = SET_W'(SETTLE_CYC - 1);

    logic tick;
    logic sync1_q, sync2_q;
    logic line, line_prev_q;
    logic rise, fall;

    state_e              state_q, state_d;
    logic [WIDTH_W-1:0]  width_q, width_d;
    logic [SET_W-1:0]    settle_q, settle_d;
    logic [TO_W-1:0]     to_cnt_q;
    logic                to_hit;

    logic [1:0]          direction_q;
    logic [WIDTH_W-1:0]  width_us_q;
    logic                valid_q, range_err_q, lost_q;

    servo_us_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Two-flop synchronizer for the asynchronous PWM line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef SERVO_GLITCH_FILTER_EN
    localparam int unsigned          FILT_W    = $clog2(FILT_CYC + 1);
    localparam logic [FILT_W-1:0]    FILT_LAST = FILT_W'(FILT_CYC - 1);

    logic              filt_line_q;
    logic [FILT_W-1:0] filt_cnt_q;

    // Accept a new level only after FILT_CYC consecutive samples that differ from the current one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_line_q <= 1'b0;
            filt_cnt_q  <= '0;
        end else if (sync2_q == filt_line_q) begin
            filt_cnt_q  <= '0;
        end else if (filt_cnt_q == FILT_LAST) begin
            filt_line_q <= sync2_q;
            filt_cnt_q  <= '0;
        end else begin
            filt_cnt_q  <= filt_cnt_q + FILT_W'(1);
        end
    end

    assign line = filt_line_q;
`else
    assign line = sync2_q;
`endif

    // Edge detect against the previous line level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line_prev_q <= 1'b0;
        end else begin
            line_prev_q <= line;
        end
    end

    assign rise = line & ~line_prev_q;
    assign fall = ~line & line_prev_q;

    // Signal-loss timer: counts us since the last rising edge, saturating at TIMEOUT_US.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else if (rise) begin
            to_cnt_q <= '0;
        end else if (tick && (to_cnt_q != TO_MAX)) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

    // Fires once, on the tick that brings the timer to TIMEOUT_US.
    assign to_hit = tick && !rise && (to_cnt_q == TO_LAST);

    // FSM, width counter and settle counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StSync;
            width_q  <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            width_q  <= width_d;
            settle_q <= settle_d;
        end
    end

    // Next-state logic: settle, wait for edge, count the high phase, then one measure cycle.
    always_comb begin
        state_d  = state_q;
        width_d  = width_q;
        settle_d = settle_q;
        unique case (state_q)
            StSync: begin
                if (line) begin
                    settle_d = '0;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d  = StIdle;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            StIdle: begin
                if (rise) begin
                    state_d = StHigh;
                    width_d = '0;
                end
            end
            StHigh: begin
                if (tick && (width_q != SAT_W)) begin
                    width_d = width_q + WIDTH_W'(1);
                end
                if (fall) begin
                    state_d = StMeas;
                end
            end
            StMeas: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StSync;
            end
        endcase
        // Signal loss aborts any measurement in progress.
        if (to_hit) begin
            state_d  = StSync;
            settle_d = '0;
        end
    end

    // Output registers: classify in MEAS, force stop/lost on timeout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            direction_q <= DIR_STOP;
            width_us_q  <= '0;
            valid_q     <= 1'b0;
            range_err_q <= 1'b0;
            lost_q      <= 1'b1;
        end else begin
            valid_q <= 1'b0;
            if (to_hit) begin
                lost_q      <= 1'b1;
                direction_q <= DIR_STOP;
            end else if (state_q == StMeas) begin
                valid_q    <= 1'b1;
                lost_q     <= 1'b0;
                width_us_q <= width_q;
                if ((width_q < MIN_W) || (width_q > MAX_W)) begin
                    range_err_q <= 1'b1;
                    direction_q <= DIR_STOP;
                end else begin
                    range_err_q <= 1'b0;
                    direction_q <= dir_from_width(32'(width_q), CW_MAX_US, CCW_MIN_US);
                end
            end
        end
    end

    assign direction = direction_q;
    assign width_us  = width_us_q;
    assign valid     = valid_q;
    assign range_err = range_err_q;
    assign lost      = lost_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Self-checking bench for servo_pwm_decoder, run with scaled-down timing parameters.
module tb_servo_pwm_decoder;

    localparam int unsigned CLK_DIV    = 2;
    localparam int unsigned WIDTH_W    = 12;
    localparam int unsigned MIN_US     = 50;
    localparam int unsigned MAX_US     = 250;
    localparam int unsigned CW_MAX_US  = 145;
    localparam int unsigned CCW_MIN_US = 155;
    localparam int unsigned TIMEOUT_US = 2500;
    localparam int unsigned FILT_CYC   = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               pwm_in;
    logic [1:0]         direction;
    logic [WIDTH_W-1:0] width_us;
    logic               valid;
    logic               range_err;
    logic               lost;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [1:0] dir;
        int         width;
        logic       err;
    } strobe_t;

    typedef struct {
        int         high_us;
        logic [1:0] dir;
        logic       err;
        int         width;
    } vec_t;

    strobe_t seen[$];
    vec_t    tbl[7];

    servo_pwm_decoder #(
        .CLK_DIV    (CLK_DIV),
        .WIDTH_W    (WIDTH_W),
        .MIN_US     (MIN_US),
        .MAX_US     (MAX_US),
        .CW_MAX_US  (CW_MAX_US),
        .CCW_MIN_US (CCW_MIN_US),
        .TIMEOUT_US (TIMEOUT_US),
        .FILT_CYC   (FILT_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pwm_in    (pwm_in),
        .direction (direction),
        .width_us  (width_us),
        .valid     (valid),
        .range_err (range_err),
        .lost      (lost)
    );

    always #5 clk = ~clk;

    // Record every VALID strobe, sampled away from the active edge.
    always @(negedge clk) begin
        strobe_t s;
        if (rst_n === 1'b1 && valid === 1'b1) begin
            s.dir   = direction;
            s.width = int'(width_us);
            s.err   = range_err;
            seen.push_back(s);
        end
    end

    // Reference: classification straight from the pulse width in us.
    function automatic void model(input int w, output logic [1:0] dir, output logic err,
                                  output int wid);
        wid = (w > int'(MAX_US)) ? int'(MAX_US) + 1 : w;
        if (w < int'(MIN_US) || w > int'(MAX_US)) begin
            err = 1'b1;
            dir = 2'b00;
        end else begin
            err = 1'b0;
            if (w <= int'(CW_MAX_US))       dir = 2'b01;
            else if (w >= int'(CCW_MIN_US)) dir = 2'b10;
            else                            dir = 2'b00;
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_tol(input string name, input int act, input int exp, input int tol);
        vectors++;
        if (act < exp - tol || act > exp + tol) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    task automatic wait_us(input int n);
        repeat (n * int'(CLK_DIV)) @(negedge clk);
    endtask

    task automatic drive_pulse(input int high_us, input int low_us);
        @(negedge clk);
        pwm_in = 1'b1;
        wait_us(high_us);
        pwm_in = 1'b0;
        wait_us(low_us);
    endtask

    task automatic expect_strobe(input string name, input logic [1:0] dir, input logic err,
                                 input int wid);
        strobe_t s;
        check({name, " strobes"}, seen.size(), 1);
        if (seen.size() > 0) begin
            s = seen.pop_front();
            check({name, " dir"}, int'(s.dir), int'(dir));
            check({name, " err"}, int'(s.err), int'(err));
            check_tol({name, " width"}, s.width, wid, 1);
        end
        seen.delete();
        check({name, " lost"}, int'(lost), 0);
    endtask

    task automatic expect_model(input string name, input int w);
        logic [1:0] d;
        logic       e;
        int         wid;
        model(w, d, e, wid);
        expect_strobe(name, d, e, wid);
    endtask

    task automatic check_reset_state(input string name);
        check({name, " dir"}, int'(direction), 0);
        check({name, " width"}, int'(width_us), 0);
        check({name, " valid"}, int'(valid), 0);
        check({name, " err"}, int'(range_err), 0);
        check({name, " lost"}, int'(lost), 1);
    endtask

    initial begin
        // Deadband edges, range violations, saturation and recovery.
        tbl[0] = '{high_us: 150, dir: 2'b00, err: 1'b0, width: 150};
        tbl[1] = '{high_us: 170, dir: 2'b10, err: 1'b0, width: 170};
        tbl[2] = '{high_us: 145, dir: 2'b01, err: 1'b0, width: 145};
        tbl[3] = '{high_us: 155, dir: 2'b10, err: 1'b0, width: 155};
        tbl[4] = '{high_us: 40,  dir: 2'b00, err: 1'b1, width: 40};
        tbl[5] = '{high_us: 300, dir: 2'b00, err: 1'b1, width: 251};
        tbl[6] = '{high_us: 170, dir: 2'b10, err: 1'b0, width: 170};

        rst_n  = 1'b0;
        pwm_in = 1'b0;
        repeat (5) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        wait_us(10);
        check("post-reset no strobe", seen.size(), 0);

        // Frames of 130 us high in a 2000 us period.
        for (int i = 0; i < 3; i++) begin
            drive_pulse(130, 1870);
            expect_strobe($sformatf("frame%0d", i), 2'b01, 1'b0, 130);
        end

        for (int i = 0; i < 7; i++) begin
            drive_pulse(tbl[i].high_us, 20);
            expect_strobe($sformatf("tbl%0d", i), tbl[i].dir, tbl[i].err, tbl[i].width);
        end

        // Signal loss: line held low after one pulse, timer runs from its rising edge.
        drive_pulse(170, 20);
        expect_strobe("pre-loss", 2'b10, 1'b0, 170);
        wait_us(2497 - 190);
        check("loss early lost", int'(lost), 0);
        wait_us(6);
        check("loss late lost", int'(lost), 1);
        check("loss dir", int'(direction), 0);
        wait_us(400);
        check("loss no strobe", seen.size(), 0);
        check("loss still lost", int'(lost), 1);
        drive_pulse(170, 20);
        expect_strobe("after-loss", 2'b10, 1'b0, 170);

        // Reset 80 us into a 170 us pulse, released with the line still high.
        @(negedge clk);
        pwm_in = 1'b1;
        wait_us(80);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check_reset_state("mid-pulse reset");
        rst_n = 1'b1;
        wait_us(90);
        pwm_in = 1'b0;
        wait_us(20);
        check("aborted pulse no strobe", seen.size(), 0);
        seen.delete();
        drive_pulse(170, 20);
        expect_strobe("first after reset", 2'b10, 1'b0, 170);

        // Two-clock glitch during the low phase.
        @(negedge clk);
        pwm_in = 1'b1;
        repeat (2) @(negedge clk);
        pwm_in = 1'b0;
        wait_us(20);
`ifdef SERVO_GLITCH_FILTER_EN
        check("glitch filtered", seen.size(), 0);
`else
        check("glitch strobes", seen.size(), 1);
        if (seen.size() > 0) begin
            strobe_t g;
            g = seen.pop_front();
            check("glitch err", int'(g.err), 1);
            check("glitch dir", int'(g.dir), 0);
            check("glitch width small", int'(g.width <= 1), 1);
        end
`endif
        seen.delete();

        // Randomized pulses against the reference model.
        for (int i = 0; i < 15; i++) begin
            int w;
            int gap;
            w   = int'($urandom_range(20, 320));
            gap = int'($urandom_range(20, 60));
            drive_pulse(w, gap);
            expect_model($sformatf("rand%0d w=%0d", i, w), w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
